fifo_rd_stream: RTL

Read-side consumer for the team's 128-bit synchronous FIFO. It drives the FIFO read port, absorbs the FIFO's one-cycle read latency in a two-entry output buffer, and presents the data as a valid/ready stream to downstream logic. Data is delivered in order, with no loss or duplication, and it sustains one word per clock when the FIFO is non-empty and the sink is ready. It also counts accepted beats, so the bench scoreboard can reconcile against words written.

---
 rtl/fifo_rd_stream.sv | 80 ++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the 128-bit synchronous FIFO: issues reads, absorbs the
// one-cycle read latency in a two-entry buffer and presents a valid/ready stream.
module fifo_rd_stream #(
   parameter int DATA_W = 128,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   output logic              o_fifo_rden,
   input  logic              i_fifo_empty,
   input  logic [DATA_W-1:0] i_fifo_rddata,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_ready,
   output logic [CNT_W-1:0]  o_beat_cnt,
   output logic              o_inflight
);

   logic [1:0]        occ_r;
   logic              inflight_r;
   logic              wr_ptr_r;
   logic              rd_ptr_r;
   logic [DATA_W-1:0] buf_r [0:1];
   logic [CNT_W-1:0]  beat_cnt_r;

   logic              pop_s;
   logic [2:0]        occ_next_s;
   logic              rden_s;

   // Occupancy after this edge: the returning word adds one, an accepted beat removes one.
   function automatic logic [2:0] occ_step(input logic [1:0] occ, input logic add, input logic sub);
      occ_step = {1'b0, occ} + {2'b00, add} - {2'b00, sub};
   endfunction

   // Pop detection and read issue; a read is only issued if its word is sure to find a free slot.
   always_comb begin
      pop_s      = 1'b0;
      occ_next_s = 3'd0;
      rden_s     = 1'b0;
      pop_s      = (occ_r != 2'd0) && i_ready;
      occ_next_s = occ_step(occ_r, inflight_r, pop_s);
      if (rstn && !i_fifo_empty && (occ_next_s < 3'd2)) begin
         rden_s = 1'b1;
      end else begin
         rden_s = 1'b0;
      end
   end

   // Buffer, pointers, occupancy, in-flight flag and beat counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occ_r      <= 2'd0;
         inflight_r <= 1'b0;
         wr_ptr_r   <= 1'b0;
         rd_ptr_r   <= 1'b0;
         buf_r[0]   <= '0;
         buf_r[1]   <= '0;
         beat_cnt_r <= '0;
      end else begin
         inflight_r <= rden_s;
         occ_r      <= occ_next_s[1:0];
         // Data on the read bus is only captured when a read was actually issued.
         if (inflight_r) begin
            buf_r[wr_ptr_r] <= i_fifo_rddata;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r   <= ~rd_ptr_r;
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
         end
      end
   end

   assign o_fifo_rden = rden_s;
   assign o_valid     = (occ_r != 2'd0);
   assign o_data      = buf_r[rd_ptr_r];
   assign o_beat_cnt  = beat_cnt_r;
   assign o_inflight  = inflight_r;

endmodule
